plusarg_watchdog: RTL and testbench

- Cycle-count watchdog that consumes the 32-bit value produced by the plusarg reader, e.g. a "+max_core_cycles=%d" style limit.
- Counts cycles since the last progress pulse.
- Raises a registered warning near the limit and a sticky timeout at the limit.
- Sits directly downstream of the plusarg reader in test harnesses. A limit of 0, the reader's usual default, disables the watchdog.

---
 rtl/plusarg_watchdog.sv | 85 ++++++++
 tb/tb_plusarg_watchdog.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plusarg_watchdog.sv
// Cycle-count watchdog fed by a plusarg limit value: counts cycles since arm or the last kick,
// flags a warning close to the limit and a sticky timeout at the limit. A limit of 0 disables it.
module plusarg_watchdog #(
   parameter int unsigned WARN_SHIFT = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] limit,
   input  logic        arm,
   input  logic        kick,
   input  logic        clear,
   output logic [31:0] count,
   output logic        warn,
   output logic        timeout,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StRun     = 2'd1,
      StWarn    = 2'd2,
      StExpired = 2'd3
   } state_e;

   state_e      state_q;
   logic [31:0] count_q;
   logic [31:0] limit_q;
   logic [31:0] warn_thr;
   logic [32:0] count_inc;

   // Incremented count carries a 33rd bit so a limit of 0xFFFFFFFF cannot overflow the compare.
   always_comb begin
      warn_thr  = limit_q - (limit_q >> WARN_SHIFT);
      count_inc = {1'b0, count_q} + 33'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         count_q <= '0;
         limit_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               count_q <= '0;
               if (arm && (limit != '0)) begin
                  limit_q <= limit;
                  state_q <= StRun;
               end
            end
            StRun, StWarn: begin
               if (clear || !arm) begin
                  state_q <= StIdle;
                  count_q <= '0;
               end else if (kick) begin
                  state_q <= StRun;
                  count_q <= '0;
               end else if (count_inc >= {1'b0, limit_q}) begin
                  // Expiry is tested first so a threshold equal to the limit skips the warning.
                  state_q <= StExpired;
                  count_q <= limit_q;
               end else if (count_inc >= {1'b0, warn_thr}) begin
                  state_q <= StWarn;
                  count_q <= count_inc[31:0];
               end else begin
                  state_q <= StRun;
                  count_q <= count_inc[31:0];
               end
            end
            StExpired: begin
               if (clear) begin
                  state_q <= StIdle;
                  count_q <= '0;
               end
            end
         endcase
      end
   end

   assign count   = count_q;
   assign state   = state_q;
   assign warn    = (state_q == StWarn);
   assign timeout = (state_q == StExpired);

endmodule

// File: tb/tb_plusarg_watchdog.sv
// Bench for plusarg_watchdog: directed scenarios with fixed expectations plus a randomized run
// checked against a cycle-level behavioural model of the watchdog.
module tb_plusarg_watchdog;

   localparam int unsigned SH = 3;

   logic        clock = 1'b0;
   logic        reset, arm, kick, clear;
   logic [31:0] limit;
   logic [31:0] count;
   logic        warn, timeout;
   logic [1:0]  state;
   logic [35:0] obs;

   int errors = 0;
   int checks = 0;

   // Model: armed flag, expired flag, elapsed cycles since start/kick, captured limit.
   bit              m_armed, m_exp;
   longint unsigned m_cnt, m_lim;

   always #5 clock = ~clock;

   assign obs = {state, count, warn, timeout};

   plusarg_watchdog #(.WARN_SHIFT(SH)) dut (
      .clock   (clock),
      .reset   (reset),
      .limit   (limit),
      .arm     (arm),
      .kick    (kick),
      .clear   (clear),
      .count   (count),
      .warn    (warn),
      .timeout (timeout),
      .state   (state)
   );

   task automatic model_step();
      if (reset) begin
         m_armed = 0; m_exp = 0; m_cnt = 0; m_lim = 0;
      end else if (!m_armed) begin
         if (arm && limit != 0) begin
            m_armed = 1; m_exp = 0; m_cnt = 0; m_lim = limit;
         end
      end else if (m_exp) begin
         if (clear) begin
            m_armed = 0; m_exp = 0; m_cnt = 0;
         end
      end else if (clear || !arm) begin
         m_armed = 0; m_cnt = 0;
      end else if (kick) begin
         m_cnt = 0;
      end else begin
         m_cnt = m_cnt + 1;
         if (m_cnt >= m_lim) begin
            m_cnt = m_lim;
            m_exp = 1;
         end
      end
   endtask

   function automatic logic [35:0] model_out();
      longint unsigned w;
      logic [1:0]      st;
      logic [31:0]     c;
      w = m_lim - (m_lim >> SH);
      if (!m_armed)        st = 2'd0;
      else if (m_exp)      st = 2'd3;
      else if (m_cnt >= w) st = 2'd2;
      else                 st = 2'd1;
      c = m_cnt[31:0];
      return {st, c, st == 2'd2, st == 2'd3};
   endfunction

   task automatic tick();
      model_step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1; arm = 0; kick = 0; clear = 0;
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      logic [35:0] e;
      reset = 1; arm = 1; limit = 5; kick = 0; clear = 0;
      tick();
      tick();
      e = '0;
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_hold: got %h want %h", obs, e); end
      reset = 0; arm = 0;
      tick();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_release: got %h want %h", obs, e); end
   endtask

   task automatic test_disabled();
      logic [35:0] e;
      do_reset();
      limit = 0; arm = 1;
      e = '0;
      for (int i = 0; i < 100; i++) begin
         tick();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL disabled cyc%0d: got %h want %h", i, obs, e);
         end
      end
   endtask

   task automatic test_expire();
      logic [35:0] e;
      do_reset();
      limit = 8; arm = 1;
      tick();
      e = {2'd1, 32'd0, 2'b00};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL expire E0: got %h want %h", obs, e); end
      for (int i = 1; i <= 6; i++) begin
         tick();
         e = {2'd1, 32'(i), 2'b00};
         checks++;
         if (obs !== e) begin errors++; $display("FAIL expire E%0d: got %h want %h", i, obs, e); end
      end
      tick();
      e = {2'd2, 32'd7, 2'b10};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL expire E7 warn: got %h want %h", obs, e); end
      tick();
      e = {2'd3, 32'd8, 2'b01};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL expire E8 timeout: got %h want %h", obs, e); end
      for (int i = 0; i < 50; i++) begin
         kick = i[0];
         tick();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL expire sticky%0d: got %h want %h", i, obs, e); end
      end
      kick = 0;
   endtask

   task automatic test_kick();
      logic [35:0] e;
      do_reset();
      limit = 8; arm = 1;
      tick();
      repeat (7) tick();
      kick = 1;
      tick();
      kick = 0;
      e = {2'd1, 32'd0, 2'b00};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL kick_in_warn: got %h want %h", obs, e); end
      repeat (7) tick();
      e = {2'd2, 32'd7, 2'b10};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL kick_rewarn: got %h want %h", obs, e); end
      kick = 1;
      tick();
      kick = 0;
      e = {2'd1, 32'd0, 2'b00};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL kick_at_expiry: got %h want %h", obs, e); end
      repeat (3) tick();
      e = {2'd1, 32'd3, 2'b00};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL kick_after: got %h want %h", obs, e); end
   endtask

   task automatic test_limit1();
      logic [35:0] e;
      do_reset();
      limit = 1; arm = 1;
      tick();
      e = {2'd1, 32'd0, 2'b00};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL limit1 E0: got %h want %h", obs, e); end
      e = {2'd3, 32'd1, 2'b01};
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL limit1 E%0d: got %h want %h", i, obs, e); end
      end
   endtask

   task automatic test_limit_change();
      logic [35:0] e;
      do_reset();
      limit = 16; arm = 1;
      tick();
      tick();
      tick();
      limit = 4;
      tick();
      e = {2'd1, 32'd3, 2'b00};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL limchg E3: got %h want %h", obs, e); end
      repeat (11) tick();
      e = {2'd2, 32'd14, 2'b10};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL limchg E14: got %h want %h", obs, e); end
      tick();
      tick();
      e = {2'd3, 32'd16, 2'b01};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL limchg E16: got %h want %h", obs, e); end
      clear = 1;
      tick();
      clear = 0;
      e = '0;
      checks++;
      if (obs !== e) begin errors++; $display("FAIL limchg clear: got %h want %h", obs, e); end
      tick();
      e = {2'd1, 32'd0, 2'b00};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL limchg rearm: got %h want %h", obs, e); end
      repeat (3) tick();
      e = {2'd1, 32'd3, 2'b00};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL limchg L4 nowarn: got %h want %h", obs, e); end
      tick();
      e = {2'd3, 32'd4, 2'b01};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL limchg L4 timeout: got %h want %h", obs, e); end
   endtask

   task automatic test_arm_drop();
      logic [35:0] e;
      do_reset();
      limit = 100; arm = 1;
      tick();
      repeat (49) tick();
      e = {2'd1, 32'd49, 2'b00};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL armdrop E49: got %h want %h", obs, e); end
      arm = 0;
      tick();
      e = '0;
      checks++;
      if (obs !== e) begin errors++; $display("FAIL armdrop E50: got %h want %h", obs, e); end
   endtask

   task automatic test_reset_mid();
      logic [35:0] e;
      do_reset();
      limit = 100; arm = 1;
      tick();
      repeat (49) tick();
      reset = 1;
      tick();
      reset = 0;
      e = '0;
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_mid E50: got %h want %h", obs, e); end
   endtask

   task automatic test_clear_armlow();
      logic [35:0] e;
      do_reset();
      limit = 8; arm = 1;
      tick();
      repeat (7) tick();
      e = {2'd2, 32'd7, 2'b10};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL clr_armlow warn: got %h want %h", obs, e); end
      clear = 1; arm = 0;
      tick();
      clear = 0;
      e = '0;
      checks++;
      if (obs !== e) begin errors++; $display("FAIL clr_armlow idle: got %h want %h", obs, e); end
   endtask

   task automatic test_random();
      logic [35:0] e;
      int unsigned r;
      do_reset();
      limit = 12;
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         arm   = ($urandom_range(0, 19) != 0);
         kick  = ($urandom_range(0, 15) == 0);
         clear = m_armed && ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 29) == 0) begin
            r = $urandom_range(0, 9);
            if (r == 0)      limit = 32'd0;
            else if (r == 1) limit = 32'hFFFF_FFFF - $urandom_range(0, 3);
            else             limit = $urandom_range(1, 40);
         end
         tick();
         e = model_out();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL random cyc%0d: got %h want %h", n, obs, e); end
      end
      reset = 0; kick = 0; clear = 0;
   endtask

   initial begin
      reset = 1; arm = 0; kick = 0; clear = 0; limit = 0;
      m_armed = 0; m_exp = 0; m_cnt = 0; m_lim = 0;
      @(negedge clock);
      test_reset();
      test_disabled();
      test_expire();
      test_kick();
      test_limit1();
      test_limit_change();
      test_arm_drop();
      test_reset_mid();
      test_clear_armlow();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
